// File: rtl/alu_issue_queue.sv
// Command FIFO feeding an external combinational ALU, with a one-entry
// registered result slot under valid/ready flow control.
module alu_issue_queue #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [W-1:0]             cmd_a,
  input  logic [W-1:0]             cmd_b,
  input  logic                     cmd_c,
  input  logic [2:0]               cmd_opc,
  output logic [W-1:0]             alu_inA,
  output logic [W-1:0]             alu_inB,
  output logic                     alu_inC,
  output logic [2:0]               alu_opc,
  input  logic [W-1:0]             alu_outW,
  input  logic                     alu_zer,
  input  logic                     alu_neg,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [W-1:0]             res_w,
  output logic                     res_zer,
  output logic                     res_neg,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2 * W + 4;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [EW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] cnt;

  logic          push;
  logic          nonempty_p0;
  logic          issue_p0;
  logic [EW-1:0] head_p0;

  logic          vld_p1;
  logic [W-1:0]  res_w_p1;
  logic          res_zer_p1;
  logic          res_neg_p1;

  // Stage p0: queue head presented to the ALU
  assign nonempty_p0 = (cnt != '0);
  assign cmd_ready   = rst_n && (cnt != FULL);
  assign push        = cmd_valid && cmd_ready;
  assign issue_p0    = nonempty_p0 && (!vld_p1 || res_ready);
  assign head_p0     = nonempty_p0 ? mem[rd_ptr] : '0;
  assign {alu_inA, alu_inB, alu_inC, alu_opc} = head_p0;

  // Storage needs no reset: an entry is only ever read after being written.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= {cmd_a, cmd_b, cmd_c, cmd_opc};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (issue_p0) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, issue_p0})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Stage p1: registered ALU result slot
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1     <= 1'b0;
      res_w_p1   <= '0;
      res_zer_p1 <= 1'b0;
      res_neg_p1 <= 1'b0;
    end else if (issue_p0) begin
      vld_p1     <= 1'b1;
      res_w_p1   <= alu_outW;
      res_zer_p1 <= alu_zer;
      res_neg_p1 <= alu_neg;
    end else if (res_ready) begin
      vld_p1     <= 1'b0;
    end
  end

  assign res_valid = vld_p1;
  assign res_w     = res_w_p1;
  assign res_zer   = res_zer_p1;
  assign res_neg   = res_neg_p1;
  assign count     = cnt;

endmodule

// File: tb/tb_alu_issue_queue.sv
// Randomized bench for alu_issue_queue: a queue-based model of the FIFO and
// result slot, plus a behavioural ALU attached to the DUT's ALU port.
module tb_alu_issue_queue;

  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  typedef logic [2*W+3:0] cmd_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [W-1:0]  cmd_a, cmd_b;
  logic          cmd_c;
  logic [2:0]    cmd_opc;
  logic [W-1:0]  alu_inA, alu_inB;
  logic          alu_inC;
  logic [2:0]    alu_opc;
  logic [W-1:0]  alu_outW;
  logic          alu_zer, alu_neg;
  logic          res_valid;
  logic          res_ready;
  logic [W-1:0]  res_w;
  logic          res_zer, res_neg;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  cmd_t         q[$];
  logic         sv;
  logic [W-1:0] sw;
  logic         sz, sn;

  always #5 clk = ~clk;

  alu_issue_queue #(.DEPTH(DEPTH), .W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_c(cmd_c), .cmd_opc(cmd_opc),
    .alu_inA(alu_inA), .alu_inB(alu_inB), .alu_inC(alu_inC), .alu_opc(alu_opc),
    .alu_outW(alu_outW), .alu_zer(alu_zer), .alu_neg(alu_neg),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_w(res_w), .res_zer(res_zer), .res_neg(res_neg),
    .count(count)
  );

  // Reference ALU: {result, zero, negative}
  function automatic logic [W+1:0] alu_fn(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic c, input logic [2:0] op);
    logic [W-1:0] r;
    case (op)
      3'd0:    r = a + b + W'(c);
      3'd1:    r = a - b - W'(c);
      3'd2:    r = a & b;
      3'd3:    r = a | b;
      3'd4:    r = a ^ b;
      3'd5:    r = ~a;
      3'd6:    r = {a[W-2:0], c};
      default: r = b;
    endcase
    return {r, (r == '0), r[W-1]};
  endfunction

  always_comb begin
    {alu_outW, alu_zer, alu_neg} = alu_fn(alu_inA, alu_inB, alu_inC, alu_opc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic cmd_t rand_cmd(input logic [2:0] op);
    return {W'($urandom), W'($urandom), 1'($urandom), op};
  endfunction

  task automatic compare_all();
    cmd_t head;
    head = (q.size() > 0) ? q[0] : '0;
    chk("cmd_ready", 32'(cmd_ready), 32'(q.size() < DEPTH));
    chk("count",     32'(count),     32'(q.size()));
    chk("res_valid", 32'(res_valid), 32'(sv));
    chk("res_w",     32'(res_w),     32'(sw));
    chk("res_zer",   32'(res_zer),   32'(sz));
    chk("res_neg",   32'(res_neg),   32'(sn));
    chk("alu_in",    32'({alu_inA, alu_inB}), head[2*W+3:4]);
    chk("alu_cop",   32'({alu_inC, alu_opc}), 32'(head[3:0]));
  endtask

  // One cycle: drive inputs, check pre-edge state, advance model over the edge.
  task automatic step(input logic v, input cmd_t cmd, input logic rr, output logic acc);
    cmd_t e;
    logic [W+1:0] r;
    @(negedge clk);
    cmd_valid = v;
    {cmd_a, cmd_b, cmd_c, cmd_opc} = cmd;
    res_ready = rr;
    #1;
    compare_all();
    acc = v && (q.size() < DEPTH);
    if (q.size() > 0 && (!sv || rr)) begin
      e = q.pop_front();
      r = alu_fn(e[2*W+3:W+4], e[W+3:4], e[3], e[2:0]);
      {sw, sz, sn} = r;
      sv = 1'b1;
    end else if (sv && rr) begin
      sv = 1'b0;
    end
    if (acc) q.push_back(cmd);
  endtask

  task automatic push_cmd(input cmd_t cmd, input logic rr);
    logic acc;
    int n;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 200) begin
      step(1'b1, cmd, rr, acc);
      n++;
    end
    if (!acc) chk("push_timeout", 0, 1);
  endtask

  task automatic drain();
    logic acc;
    int n;
    n = 0;
    while ((q.size() > 0 || sv) && n < 200) begin
      step(1'b0, '0, 1'b1, acc);
      n++;
    end
    if (q.size() > 0 || sv) chk("drain_timeout", 0, 1);
  endtask

  task automatic reset_mid();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    cmd_valid = 1'b1;
    #1;
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(res_valid), 0);
    chk("rst_w", 32'(res_w), 0);
    chk("rst_flags", 32'({res_zer, res_neg}), 0);
    chk("rst_ready", 32'(cmd_ready), 0);
    chk("rst_alu", 32'({alu_inA, alu_inB, alu_inC, alu_opc}), 0);
    q.delete();
    sv = 1'b0; sw = '0; sz = 1'b0; sn = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    logic acc;
    int sent, n;
    rst_n = 1'b0;
    cmd_valid = 1'b1;
    {cmd_a, cmd_b, cmd_c, cmd_opc} = '1;
    res_ready = 1'b0;
    sv = 1'b0; sw = '0; sz = 1'b0; sn = 1'b0;
    #3;
    chk("init_count", 32'(count), 0);
    chk("init_valid", 32'(res_valid), 0);
    chk("init_w", 32'(res_w), 0);
    chk("init_ready", 32'(cmd_ready), 0);
    chk("init_alu", 32'({alu_inA, alu_inB, alu_inC, alu_opc}), 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cmd_valid = 1'b0;

    // Single command latency: FFFE + 3 = 0001
    step(1'b1, {16'hFFFE, 16'h0003, 1'b0, 3'd0}, 1'b1, acc);
    step(1'b0, '0, 1'b1, acc);
    chk("lat_inA", 32'(alu_inA), 32'h0000FFFE);
    chk("lat_inB", 32'(alu_inB), 32'h00000003);
    step(1'b0, '0, 1'b1, acc);
    chk("lat_valid", 32'(res_valid), 1);
    chk("lat_w", 32'(res_w), 32'h00000001);
    drain();

    // Opcode sweep, back to back
    for (int op = 0; op < 8; op++) push_cmd(rand_cmd(3'(op)), 1'b1);
    drain();

    // Backpressure: fill the queue behind a stalled result
    for (int i = 0; i < 6; i++) step(1'b1, rand_cmd(3'(i)), 1'b0, acc);
    chk("full_count", 32'(count), 4);
    chk("full_ready", 32'(cmd_ready), 0);
    chk("full_acc", 32'(acc), 0);
    for (int i = 0; i < 3; i++) step(1'b1, {16'h8000, 16'h0001, 1'b1, 3'd1}, 1'b0, acc);
    push_cmd({16'h8000, 16'h0001, 1'b1, 3'd1}, 1'b1);
    drain();

    // Random valid/ready traffic
    sent = 0;
    n = 0;
    while (sent < 200 && n < 5000) begin
      if ($urandom_range(0, 3) != 0) begin
        step(1'b1, rand_cmd(3'($urandom)), 1'($urandom_range(0, 2) != 0), acc);
        if (acc) sent++;
      end else begin
        step(1'b0, '0, 1'($urandom), acc);
      end
      n++;
    end
    if (sent < 200) chk("random_timeout", 32'(sent), 200);
    drain();

    // Reset with count=3 and a held result
    for (int i = 0; i < 4; i++) push_cmd(rand_cmd(3'(i)), 1'b0);
    step(1'b0, '0, 1'b0, acc);
    chk("pre_rst_count", 32'(count), 3);
    chk("pre_rst_valid", 32'(res_valid), 1);
    reset_mid();
    step(1'b1, {16'h1234, 16'h00FF, 1'b0, 3'd2}, 1'b1, acc);
    step(1'b0, '0, 1'b1, acc);
    step(1'b0, '0, 1'b1, acc);
    chk("post_rst_valid", 32'(res_valid), 1);
    chk("post_rst_w", 32'(res_w), 32'h00000034);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
